// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/response bus between the fetch
// stage and the instruction ROM.
//   rom_en    : fetch request (driven by fetch stage)
//   rom_addr  : fetch address (driven by fetch stage)
//   rom_rdata : returned instruction (driven by memory)
//   rom_valid : rom_rdata valid for the outstanding request (driven by memory)
// Modports: master = fetch stage, slave = memory.
interface if_fetch_if;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic        rom_valid;

  modport master (output rom_en, output rom_addr, input rom_rdata, input rom_valid);
  modport slave  (input rom_en, input rom_addr, output rom_rdata, output rom_valid);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a one-entry stall buffer and
// flush/redirect handling of an outstanding memory request.
// Parameters:
//   RESET_PC   : first fetch address after reset
// Ports:
//   clk        : pipeline clock, rising edge
//   rst        : asynchronous active-low reset
//   stall      : 1 = ID not accepting, IF/ID outputs hold
//   flush      : redirect request (priority over stall and rom_valid)
//   flush_pc   : redirect target (low two bits ignored)
//   rom        : if_fetch_if.master instruction memory bus
//   addr/inst/inst_valid : registered IF/ID pair to the ID stage
// Optional feature (macro IF_FETCH_PERF_CNT_EN):
//   perf_fetch_cnt : delivered instructions, saturating
//   perf_wait_cnt  : FETCH cycles without rom_valid, saturating
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  if_fetch_if.master  rom,
  output logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buf_inst, buf_nxt;
  logic        rom_en_q;
  logic        deliver;
  logic [31:0] deliver_inst;

  assign rom.rom_en   = rom_en_q;
  assign rom.rom_addr = pc;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    buf_nxt      = buf_inst;
    deliver      = 1'b0;
    deliver_inst = buf_inst;
    if (flush) begin
      pc_nxt  = {flush_pc[31:2], 2'b00};
      buf_nxt = '0;
      case (state)
        // a request still in flight must have its response dropped
        FETCH:   state_nxt = rom.rom_valid ? FETCH : DISCARD;
        DISCARD: state_nxt = DISCARD;
        default: state_nxt = FETCH;
      endcase
    end else begin
      case (state)
        IDLE: state_nxt = FETCH;
        FETCH: begin
          if (rom.rom_valid) begin
            if (stall) begin
              buf_nxt   = rom.rom_rdata;
              state_nxt = HOLD;
            end else begin
              deliver      = 1'b1;
              deliver_inst = rom.rom_rdata;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_inst = buf_inst;
            state_nxt    = FETCH;
          end
        end
        DISCARD: if (rom.rom_valid) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
      if (deliver) pc_nxt = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      buf_inst   <= '0;
      rom_en_q   <= 1'b0;
      addr       <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      buf_inst <= buf_nxt;
      rom_en_q <= (state_nxt == FETCH);
      if (flush || (!deliver && !stall)) begin
        addr       <= '0;
        inst       <= '0;
        inst_valid <= 1'b0;
      end else if (deliver) begin
        addr       <= pc;
        inst       <= deliver_inst;
        inst_valid <= 1'b1;
      end
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (deliver && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == FETCH && !rom.rom_valid && perf_wait_cnt != '1)
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  input  1  pipeline clock, rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold request from pipeline control; 1 = ID not accepting.
REQ-005 flush  input  1  redirect request; flush_pc  input  32  redirect target.
REQ-006 rom_en  output  1  fetch request; rom_addr  output  32  fetch address.
REQ-007 rom_rdata  input  32  returned instruction; rom_valid  input  1  rom_rdata valid for the outstanding request.
REQ-008 addr  output  32  / inst  output  32  / inst_valid  output  1  registered IF/ID pair to the ID stage.

Function
REQ-009 SHALL hold pc (32 b), state {IDLE, FETCH, HOLD, DISCARD}, buffer buf_inst (32 b).
REQ-010 rom_addr SHALL equal pc; rom_en SHALL be 1 only in FETCH.
REQ-011 IDLE: rom_en=0; next cycle -> FETCH.
REQ-012 FETCH with rom_valid=0: pc and rom_addr held stable, rom_en held 1.
REQ-013 FETCH, rom_valid=1, stall=0: addr<=pc, inst<=rom_rdata, inst_valid<=1, pc<=pc+4, stay FETCH; sustained 1 instr/cycle with zero-wait memory.
REQ-014 FETCH, rom_valid=1, stall=1: buf_inst<=rom_rdata, -> HOLD; outputs unchanged.
REQ-015 HOLD: rom_en=0; when stall=0: addr<=pc, inst<=buf_inst, inst_valid<=1, pc<=pc+4, -> FETCH.
REQ-016 stall=1 (no flush): addr, inst, inst_valid SHALL hold their values.
REQ-017 stall=0 with no instruction delivered that cycle: inst_valid<=0, inst<=0, addr<=0 (bubble).
REQ-018 flush SHALL take priority over stall and rom_valid: pc<={flush_pc[31:2],2'b00}; addr<=0, inst<=0, inst_valid<=0; buf_inst discarded.
REQ-019 flush in FETCH with rom_valid=0 -> DISCARD; with rom_valid=1 -> response dropped, stay FETCH at new pc.
REQ-020 flush in IDLE or HOLD -> FETCH at new pc.
REQ-021 DISCARD: rom_en=0; on rom_valid=1 drop rom_rdata, -> FETCH; further flush in DISCARD updates pc, stays DISCARD.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 rom_valid outside FETCH/DISCARD SHALL be ignored.

Reset
REQ-024 rst=0 SHALL asynchronously set pc=RESET_PC, state=IDLE, rom_en=0, addr=0, inst=0, inst_valid=0, buf_inst=0.
REQ-025 Reset mid-fetch SHALL abandon the outstanding request; a rom_valid in the first cycle after release SHALL be ignored (IDLE).

Configuration
REQ-026 Macro IF_FETCH_PERF_CNT_EN defined: SHALL add outputs perf_fetch_cnt (32) counting delivered instructions and perf_wait_cnt (32) counting FETCH cycles with rom_valid=0; both saturate at 32'hFFFF_FFFF, reset to 0.
REQ-027 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset release, rom_valid tied 1, rom_rdata=pc^32'hA5A5_A5A5, stall=0 -> addr 0,4,8,... on consecutive cycles, inst_valid=1 from third cycle after release.
REQ-029 rom_valid delayed 3 cycles per request -> rom_addr stable 3 cycles, inst_valid pulses 1 every 4 cycles, no bubble carries stale inst.
REQ-030 stall=1 for 5 cycles during FETCH with rom_valid=1 -> HOLD, outputs frozen, on release buffered inst at addr 0x10 delivered once, next rom_addr 0x14.
REQ-031 flush with flush_pc=32'h0000_1003 while request outstanding -> DISCARD, late rom_valid dropped, next rom_addr 32'h0000_1000, inst_valid=0 until its data returns.
REQ-032 flush and stall and rom_valid in same cycle -> inst_valid=0, pc=flush_pc, response dropped.
REQ-033 RESET_PC=32'hFFFF_FFF8, zero-wait -> addr FFFF_FFF8, FFFF_FFFC, 0000_0000; async reset mid-stream clears outputs without clock edge.
